// File: rtl/imem_loader_pkg.sv
// Shared types for the imem program loader.
// Loader FSM states and stream framing constants.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        S_LEN,
        S_DATA,
        S_RUN,
        S_ERR
    } state_t;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_prog_loader_asm.sv
// Little-endian byte-to-word assembler.
// Used for both the length prefix and the image words.
module byte_word_asm
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int IW = $clog2(WORD_BYTES);

    logic [IW-1:0] idx;
    logic [23:0]   acc;
    logic          last;

    assign last       = (idx == IW'(WORD_BYTES - 1));
    assign word_valid = en & last;
    // Earlier bytes shift down so byte0 ends in [7:0].
    assign word       = {din, acc};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx <= '0;
            acc <= '0;
        end else if (clr) begin
            idx <= '0;
            acc <= '0;
        end else if (en) begin
            idx <= idx + IW'(1);
            acc <= {din, acc[23:8]};
        end
    end

endmodule

// File: rtl/imem_prog_loader.sv
// Byte-stream program loader writing 32-bit words into imem.
// Holds the core in reset until a complete image is committed.
module imem_prog_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rstn,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [32:0]       CAP  = 33'd1 << ADDR_W;

    state_t          state;
    state_t          state_n;
    logic            fin;
    logic [ADDR_W:0] remaining;
    logic            asm_en;
    logic            wv;
    logic [31:0]     word;
    logic            len_zero;
    logic            len_big;

    // fin marks the cycle the last write is on the bus.
    assign in_ready = rstn & ~fin & ((state == S_LEN) | (state == S_DATA));
    assign asm_en   = in_valid & in_ready & ~load_req;
    assign cpu_rstn = (state == S_RUN);
    assign done     = (state == S_RUN);
    assign err      = (state == S_ERR);
    assign len_zero = (word == 32'd0);
    assign len_big  = ({1'b0, word} > CAP);

    byte_word_asm u_asm (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (load_req),
        .en         (asm_en),
        .din        (in_data),
        .word       (word),
        .word_valid (wv)
    );

    always_comb begin
        state_n = state;
        if (load_req) begin
            state_n = S_LEN;
        end else begin
            unique case (state)
                S_LEN: begin
                    if (wv) begin
                        if (len_zero)
                            state_n = S_RUN;
                        else if (len_big)
                            state_n = S_ERR;
                        else
                            state_n = S_DATA;
                    end
                end
                S_DATA: begin
                    if (fin)
                        state_n = S_RUN;
                end
                S_RUN:   state_n = S_RUN;
                S_ERR:   state_n = S_ERR;
                default: state_n = S_LEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_LEN;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            imem_we      <= 1'b0;
            imem_addr    <= BASE;
            imem_wdata   <= 32'd0;
            words_loaded <= '0;
            remaining    <= '0;
            fin          <= 1'b0;
        end else if (load_req) begin
            imem_we      <= 1'b0;
            imem_addr    <= BASE;
            words_loaded <= '0;
            remaining    <= '0;
            fin          <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            fin     <= 1'b0;
            if (wv && state == S_LEN && !len_zero && !len_big)
                remaining <= word[ADDR_W:0];
            if (wv && state == S_DATA) begin
                imem_we      <= 1'b1;
                imem_wdata   <= word;
                imem_addr    <= BASE + words_loaded[ADDR_W-1:0];
                words_loaded <= words_loaded + (ADDR_W+1)'(1);
                remaining    <= remaining - (ADDR_W+1)'(1);
                fin          <= (remaining == (ADDR_W+1)'(1));
            end
        end
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader.
// Vector table of whole loads plus abort/reset/gap sequences.
module tb_imem_prog_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          load_req = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rstn;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    imem_prog_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .load_req     (load_req),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rstn     (cpu_rstn),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_we = -1;
    int last_acc = -1;
    int done_rise = -1;
    int ovl = 0;
    int stalls = 0;
    logic done_p = 1'b0;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
            last_we = cyc;
            if (cpu_rstn || done) ovl++;
        end
        if (in_valid && in_ready) last_acc = cyc;
        if (done && !done_p) done_rise = cyc;
        done_p = done;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        if (gap > 0)
            while ($urandom_range(99) < gap) idle(1);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 40) begin
            idle(1);
            w++;
        end
        stalls += w;
        idle(1);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        last_we   = -1;
        done_rise = -1;
        stalls    = 0;
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        idle(1);
        load_req = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [31:0] len;
        int          nw;
        logic [31:0] w[4];
        bit          exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int a0;
        int nm;
        vecs[0] = '{"len2", 32'd2, 2, '{32'h00000013, 32'h00500093, 32'h0, 32'h0}, 1'b0};
        vecs[1] = '{"len0", 32'd0, 0, '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b0};
        vecs[2] = '{"len257", 32'd257, 0, '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b1};
        vecs[3] = '{"len1", 32'd1, 1, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, 1'b0};
        vecs[4] = '{"len3", 32'd3, 3, '{32'h11223344, 32'hAABBCCDD, 32'h01020304, 32'h0}, 1'b0};
        vecs[5] = '{"len64k", 32'h00010000, 0, '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b1};
        vecs[6] = '{"lenhi", 32'h80000001, 0, '{32'h0, 32'h0, 32'h0, 32'h0}, 1'b1};

        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_cpu", cpu_rstn, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wl", words_loaded, 0);
        idle(2);
        rstn = 1'b1;
        #1;
        chk("rel_ready", in_ready, 1);

        for (int v = 0; v < 7; v++) begin
            pulse_req();
            clear_log();
            send_word(vecs[v].len, 0);
            if (!vecs[v].exp_err)
                for (int i = 0; i < vecs[v].nw; i++) send_word(vecs[v].w[i], 0);
            idle(3);
            chk({vecs[v].name, "_done"}, done, vecs[v].exp_err ? 0 : 1);
            chk({vecs[v].name, "_cpu"}, cpu_rstn, vecs[v].exp_err ? 0 : 1);
            chk({vecs[v].name, "_err"}, err, vecs[v].exp_err ? 1 : 0);
            chk({vecs[v].name, "_ready"}, in_ready, 0);
            chk({vecs[v].name, "_wl"}, words_loaded, vecs[v].exp_err ? 0 : vecs[v].nw);
            chk({vecs[v].name, "_nwr"}, wa.size(), vecs[v].exp_err ? 0 : vecs[v].nw);
            chk({vecs[v].name, "_stall"}, stalls, 0);
            if (!vecs[v].exp_err) begin
                for (int i = 0; i < vecs[v].nw; i++) begin
                    chk({vecs[v].name, "_addr"}, (i < wa.size()) ? wa[i] : 'x, i);
                    chk({vecs[v].name, "_data"}, (i < wd.size()) ? wd[i] : 'x, vecs[v].w[i]);
                end
                if (vecs[v].nw > 0)
                    chk({vecs[v].name, "_rise"}, done_rise - last_we, 1);
                else
                    chk({vecs[v].name, "_rise0"}, done_rise - last_acc, 1);
            end
            a0 = last_acc;
            in_valid = 1'b1;
            in_data  = 8'h5A;
            idle(3);
            in_valid = 1'b0;
            chk({vecs[v].name, "_stray"}, last_acc, a0);
            chk({vecs[v].name, "_nwr2"}, wa.size(), vecs[v].exp_err ? 0 : vecs[v].nw);
        end

        // full-capacity image
        pulse_req();
        clear_log();
        send_word(32'd256, 0);
        for (int i = 0; i < 256; i++) send_word(32'hA5000000 + i, 0);
        idle(3);
        chk("full_done", done, 1);
        chk("full_err", err, 0);
        chk("full_wl", words_loaded, 256);
        chk("full_nwr", wa.size(), 256);
        nm = 0;
        for (int i = 0; i < 256 && i < wa.size(); i++)
            if (wa[i] !== AW'(i) || wd[i] !== 32'hA5000000 + i) nm++;
        chk("full_map", nm, 0);
        chk("full_rise", done_rise - last_we, 1);

        // 16 words with ~30% idle gaps
        pulse_req();
        clear_log();
        send_word(32'd16, 30);
        for (int i = 0; i < 16; i++) send_word(32'h0F000000 + 3 * i, 30);
        idle(3);
        chk("gap_done", done, 1);
        chk("gap_nwr", wa.size(), 16);
        chk("gap_stall", stalls, 0);
        nm = 0;
        for (int i = 0; i < 16 && i < wa.size(); i++)
            if (wa[i] !== AW'(i) || wd[i] !== 32'h0F000000 + 3 * i) nm++;
        chk("gap_map", nm, 0);
        chk("gap_rise", done_rise - last_we, 1);

        // abort partway through word 3
        pulse_req();
        clear_log();
        send_word(32'd4, 0);
        for (int i = 0; i < 3; i++) send_word(32'h100 + i, 0);
        send_byte(8'h77, 0);
        send_byte(8'h66, 0);
        pulse_req();
        idle(3);
        chk("abort_nwr", wa.size(), 3);
        chk("abort_cpu", cpu_rstn, 0);
        chk("abort_done", done, 0);
        chk("abort_wl", words_loaded, 0);
        chk("abort_ready", in_ready, 1);
        clear_log();
        send_word(32'd1, 0);
        send_word(32'hCAFEF00D, 0);
        idle(3);
        chk("reload_nwr", wa.size(), 1);
        chk("reload_addr", (wa.size() > 0) ? wa[0] : 'x, 0);
        chk("reload_data", (wd.size() > 0) ? wd[0] : 'x, 32'hCAFEF00D);
        chk("reload_done", done, 1);
        chk("reload_cpu", cpu_rstn, 1);

        // async reset while a write is on the bus
        pulse_req();
        clear_log();
        send_word(32'd3, 0);
        send_word(32'h12345678, 0);
        chk("mid_we", imem_we, 1);
        #2 rstn = 1'b0;
        #1;
        chk("ar_we", imem_we, 0);
        chk("ar_ready", in_ready, 0);
        chk("ar_addr", imem_addr, 0);
        chk("ar_wdata", imem_wdata, 0);
        chk("ar_wl", words_loaded, 0);
        chk("ar_cpu", cpu_rstn, 0);
        chk("ar_done", done, 0);
        chk("ar_err", err, 0);
        idle(2);
        rstn = 1'b1;
        #1;
        chk("ar_rel_ready", in_ready, 1);
        clear_log();
        send_word(32'd1, 0);
        send_word(32'h00100073, 0);
        idle(3);
        chk("ar_load_nwr", wa.size(), 1);
        chk("ar_load_data", (wd.size() > 0) ? wd[0] : 'x, 32'h00100073);
        chk("ar_load_done", done, 1);

        chk("we_overlap", ovl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
